// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - DREQ/mask arbitration with HRQ/HLDA handshake and one-hot DACK
module dma_priority_resolver #(
   parameter int NUM_CH = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [3:0] DREQ,
   input  logic [3:0] maskedChannels,
   input  logic       rotatingPriority,
   input  logic       HLDA,
   input  logic       transferDone,
   output logic       HRQ,
   output logic [3:0] DACK,
   output logic [1:0] activeChannel,
   output logic       serviceActive
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] act_q, act_d;
   logic [1:0] ptr_q, ptr_d;
   logic       hrq_q, hrq_d;
   logic [3:0] dack_q, dack_d;

   logic [3:0] elig;
   logic [1:0] start_ch;
   logic [1:0] cand;
   logic [1:0] win_ch;
   logic       win_found;

   assign elig = DREQ & ~maskedChannels;

   // Scan from the highest-priority channel; fixed mode always starts at ch0.
   always_comb begin
      win_found = 1'b0;
      win_ch    = 2'd0;
      cand      = 2'd0;
      start_ch  = rotatingPriority ? ptr_q : 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = start_ch + 2'(i);
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_ch    = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               act_d   = win_ch;
               state_d = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (!elig[act_q]) begin
               state_d = ST_IDLE;
            end else if (HLDA) begin
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            // Completion wins over a simultaneous HLDA drop, so rotation still applies.
            if (transferDone) begin
               state_d = ST_IDLE;
               if (rotatingPriority) begin
                  ptr_d = act_q + 2'd1;
               end
            end else if (!HLDA) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // HRQ lags the winner latch by one edge and drops with the return to IDLE.
      hrq_d  = (state_q != ST_IDLE) && (state_d != ST_IDLE);
      dack_d = (state_d == ST_SERVICE) ? (4'b0001 << act_d) : 4'b0000;
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         act_q   <= 2'd0;
         ptr_q   <= 2'd0;
         hrq_q   <= 1'b0;
         dack_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         ptr_q   <= ptr_d;
         hrq_q   <= hrq_d;
         dack_q  <= dack_d;
      end
   end

   assign HRQ           = hrq_q;
   assign DACK          = dack_q;
   assign activeChannel = act_q;
   assign serviceActive = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_dma_priority_resolver.sv
// tb/tb_dma_priority_resolver.sv - directed and randomized checks of dma_priority_resolver against a behavioural model
module tb_dma_priority_resolver;

   logic       CLK = 1'b0;
   logic       reset;
   logic [3:0] DREQ;
   logic [3:0] maskedChannels;
   logic       rotatingPriority;
   logic       HLDA;
   logic       transferDone;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] activeChannel;
   logic       serviceActive;

   int checks   = 0;
   int failures = 0;

   dma_priority_resolver #(.NUM_CH(4)) dut (
      .CLK              (CLK),
      .reset            (reset),
      .DREQ             (DREQ),
      .maskedChannels   (maskedChannels),
      .rotatingPriority (rotatingPriority),
      .HLDA             (HLDA),
      .transferDone     (transferDone),
      .HRQ              (HRQ),
      .DACK             (DACK),
      .activeChannel    (activeChannel),
      .serviceActive    (serviceActive)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = idle, 1 = waiting for HLDA, 2 = granted.
   int m_phase = 0;
   int m_ch    = 0;
   int m_ptr   = 0;
   int m_hrq   = 0;
   bit model_valid = 0;

   function automatic int pick(input int elig, input int first);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (first + k) % 4;
         if ((elig >> c) & 1) return c;
      end
      return -1;
   endfunction

   always @(posedge CLK) begin
      int e;
      e = DREQ & ~maskedChannels;
      if (!reset) begin
         m_phase = 0; m_ch = 0; m_ptr = 0; m_hrq = 0;
         model_valid = 1;
      end else if (m_phase == 0) begin
         m_hrq = 0;
         if (e != 0) begin
            m_ch    = pick(e, rotatingPriority ? m_ptr : 0);
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (((e >> m_ch) & 1) == 0) begin
            m_phase = 0; m_hrq = 0;
         end else begin
            m_hrq = 1;
            if (HLDA) m_phase = 2;
         end
      end else begin
         if (transferDone) begin
            m_phase = 0; m_hrq = 0;
            if (rotatingPriority) m_ptr = (m_ch + 1) % 4;
         end else if (!HLDA) begin
            m_phase = 0; m_hrq = 0;
         end else begin
            m_hrq = 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (model_valid) begin
         chk("model_hrq", HRQ, m_hrq);
         chk("model_dack", DACK, (m_phase == 2) ? (1 << m_ch) : 0);
         chk("model_active", activeChannel, m_ch);
         chk("model_svc", serviceActive, (m_phase == 2) ? 1 : 0);
         chk("onehot", ($countones(DACK) <= 1) ? 1 : 0, 1);
         if (DACK != 0) chk("dack_implies_hrq_svc", HRQ & serviceActive, 1);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic wait_svc(input string nm);
      for (int n = 0; n < 20 && !serviceActive; n++) tick();
      if (!serviceActive) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic pulse_done();
      transferDone = 1'b1;
      tick();
      transferDone = 1'b0;
   endtask

   int exp_rot[5] = '{1, 2, 4, 8, 1};

   initial begin
      reset = 1'b0; DREQ = 4'b0; maskedChannels = 4'b0;
      rotatingPriority = 1'b0; HLDA = 1'b0; transferDone = 1'b0;
      do_reset();
      chk("reset_hrq", HRQ, 0);
      chk("reset_dack", DACK, 0);
      chk("reset_active", activeChannel, 0);
      chk("reset_svc", serviceActive, 0);

      // Fixed priority
      DREQ = 4'b1010;
      tick();
      chk("fix_latch", activeChannel, 1);
      chk("fix_hrq_early", HRQ, 0);
      tick();
      chk("fix_hrq", HRQ, 1);
      HLDA = 1'b1;
      tick();
      chk("fix_dack", DACK, 4'b0010);
      pulse_done();
      chk("fix_done_dack", DACK, 0);
      chk("fix_done_hrq", HRQ, 0);
      wait_svc("fix_again");
      chk("fix_again_ch", activeChannel, 1);
      HLDA = 1'b0;

      // Rotating priority
      rotatingPriority = 1'b1; DREQ = 4'b1111; HLDA = 1'b1;
      do_reset();
      for (int s = 0; s < 5; s++) begin
         wait_svc("rot");
         chk("rot_dack", DACK, exp_rot[s]);
         pulse_done();
      end

      // Masking
      rotatingPriority = 1'b0; maskedChannels = 4'b1011;
      do_reset();
      wait_svc("mask");
      chk("mask_dack", DACK, 4'b0100);
      HLDA = 1'b0;
      pulse_done();
      for (int n = 0; n < 20 && !HRQ; n++) tick();
      chk("mask_req_hrq", HRQ, 1);
      maskedChannels = 4'b1111;
      tick();
      chk("mask_drop_hrq", HRQ, 0);
      chk("mask_drop_dack", DACK, 0);
      repeat (3) begin
         tick();
         chk("mask_idle_hrq", HRQ, 0);
         chk("mask_idle_dack", DACK, 0);
      end

      // Abort on ch3 keeps the pointer
      maskedChannels = 4'b0000; rotatingPriority = 1'b1; HLDA = 1'b1;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         wait_svc("abort_pre");
         pulse_done();
      end
      wait_svc("abort_ch3");
      chk("abort_ch3", activeChannel, 3);
      HLDA = 1'b0;
      tick();
      chk("abort_dack", DACK, 0);
      HLDA = 1'b1;
      wait_svc("abort_next");
      chk("abort_next_ch", activeChannel, 3);

      // Reset during service
      do_reset();
      for (int s = 0; s < 2; s++) begin
         wait_svc("rst_pre");
         pulse_done();
      end
      wait_svc("rst_svc");
      chk("rst_svc_dack", DACK, 4'b0100);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst_hrq", HRQ, 0);
      chk("rst_dack", DACK, 0);
      chk("rst_svc", serviceActive, 0);
      wait_svc("rst_after");
      chk("rst_after_ch", activeChannel, 0);

      // Latency
      DREQ = 4'b0000; HLDA = 1'b0; rotatingPriority = 1'b0;
      do_reset();
      tick();
      DREQ = 4'b0001;
      tick();
      chk("lat_hrq_k1", HRQ, 0);
      tick();
      chk("lat_hrq_k2", HRQ, 1);
      HLDA = 1'b1;
      tick();
      chk("lat_dack", DACK, 4'b0001);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         reset            = ($urandom_range(0, 299) != 0);
         DREQ             = 4'($urandom);
         maskedChannels   = 4'($urandom & $urandom);
         if ($urandom_range(0, 49) == 0) rotatingPriority = ~rotatingPriority;
         HLDA             = ($urandom_range(0, 9) < 8);
         transferDone     = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
